// File: rtl/prefix_divider8.sv
// prefix_divider8 -- sequential 8-bit unsigned restoring divider.
//
// Produces one quotient bit per clock. Each trial subtraction is formed by
// a parallel-prefix (Kogge-Stone) adder as S + ~D + 1. The divider is
// controlled by a start/done handshake.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset to IDLE
//   start        request a division (sampled on the rising edge)
//   dividend     unsigned dividend, captured on an accepted start
//   divisor      unsigned divisor, captured on an accepted start
//   busy         high while iterating
//   done         one-cycle pulse marking valid results
//   quotient     result quotient, held until the next accepted start
//   remainder    result remainder, held until the next accepted start
//   div_by_zero  set with done when the divisor was zero

// prefixAdder -- 8-bit Kogge-Stone adder with a generate/propagate carry-in
// slot at position -1.
//
// Ports:
//   ai, bi     addend bits
//   g_minus1   generate of position -1 (acts as carry-in)
//   p_minus1   propagate of position -1
//   sum        8-bit sum
//   cout       carry out of bit 7
module prefixAdder (
  input  logic [7:0] ai,
  input  logic [7:0] bi,
  input  logic       g_minus1,
  input  logic       p_minus1,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] halfSum;
  logic [8:0] gen;
  logic [8:0] prop;
  logic [8:0] genNext;
  logic [8:0] propNext;

  assign halfSum = ai ^ bi;

  // Prefix tree over nine positions. Index 0 holds position -1, so after the
  // last level gen[j] is the carry into bit j and gen[8] is the carry out.
  always_comb begin
    gen      = {ai & bi, g_minus1};
    prop     = {halfSum, p_minus1};
    genNext  = gen;
    propNext = prop;
    for (int d = 1; d < 9; d = d * 2) begin
      genNext  = gen;
      propNext = prop;
      for (int j = d; j < 9; j++) begin
        genNext[j]  = gen[j] | (prop[j] & gen[j-d]);
        propNext[j] = prop[j] & prop[j-d];
      end
      gen  = genNext;
      prop = propNext;
    end
  end

  assign sum  = halfSum ^ gen[7:0];
  assign cout = gen[8];

endmodule

module prefix_divider8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] count_q, count_d;
  // Partial remainder kept as 8 bits: it is always below the divisor, so
  // its ninth bit is zero between iterations.
  logic [7:0] pRem_q, pRem_d;
  logic [7:0] qReg_q, qReg_d;
  logic [7:0] dReg_q, dReg_d;
  logic [7:0] quot_q, quot_d;
  logic [7:0] rem_q, rem_d;
  logic       dbz_q, dbz_d;

  logic [8:0] shifted;
  logic [7:0] trialSum;
  logic       trialCout;
  logic       noBorrow;
  logic [7:0] iterP;
  logic [7:0] iterQ;

  // Trial subtraction S - D as S + ~D + 1. The carry-in comes from the
  // generate slot at position -1.
  prefixAdder uTrialAdd (
    .ai       (shifted[7:0]),
    .bi       (~dReg_q),
    .g_minus1 (1'b1),
    .p_minus1 (1'b0),
    .sum      (trialSum),
    .cout     (trialCout)
  );

  // One restoring iteration. If S[8] is set, S >= 256 > D, so the subtraction
  // cannot borrow. On a borrow S[8] is zero, so keeping only S[7:0] is exact.
  always_comb begin
    shifted  = {pRem_q, qReg_q[7]};
    noBorrow = shifted[8] | trialCout;
    iterP    = noBorrow ? trialSum : shifted[7:0];
    iterQ    = {qReg_q[6:0], noBorrow};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 3'd0;
      pRem_q  <= 8'd0;
      qReg_q  <= 8'd0;
      dReg_q  <= 8'd0;
      quot_q  <= 8'd0;
      rem_q   <= 8'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pRem_q  <= pRem_d;
      qReg_q  <= qReg_d;
      dReg_q  <= dReg_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic. A start is honoured in IDLE and in DONE, which allows
  // back-to-back operations. A start during RUN is ignored.
  // Results update only on entry to DONE. Otherwise the previous result is held.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pRem_d  = pRem_q;
    qReg_d  = qReg_q;
    dReg_d  = dReg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (divisor != 8'd0) begin
            state_d = RUN;
            qReg_d  = dividend;
            pRem_d  = 8'd0;
            dReg_d  = divisor;
            count_d = 3'd0;
            dbz_d   = 1'b0;
          end else begin
            state_d = DONE;
            quot_d  = 8'hFF;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        pRem_d  = iterP;
        qReg_d  = iterQ;
        count_d = count_q + 3'd1;
        if (count_q == 3'd7) begin
          state_d = DONE;
          quot_d  = iterQ;
          rem_d   = iterP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_prefix_divider8.sv
// tb_prefix_divider8 -- self-checking bench for prefix_divider8.
//
// Expected results come from plain integer '/' and '%'. Expected timing is
// 8 busy cycles followed by done, or an immediate done for a zero divisor.
`timescale 1ns/1ps
module tb_prefix_divider8;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  // Last result the outputs are expected to hold while a new operation runs.
  logic [7:0] expQ = 8'd0;
  logic [7:0] expR = 8'd0;
  logic       expZ = 1'b0;

  prefix_divider8 dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: if the bench stalls, report it and stop.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Issue one operation and follow it to done, bounded at 20 cycles.
  // lat is the number of falling edges after the accepting edge until done
  // is seen (0 means it never arrived). holdErr counts cycles in which the
  // held results moved or busy and done overlapped.
  task automatic doOp(input logic [7:0] a, input logic [7:0] b,
                      input bit sameCycle, output int lat,
                      output int busyCnt, output int holdErr);
    if (!sameCycle) @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    lat = 0;
    busyCnt = 0;
    holdErr = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy && done) holdErr++;
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busyCnt++;
      if (quotient !== expQ || remainder !== expR || div_by_zero !== 1'b0) holdErr++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    dividend = 8'd0;
    divisor = 8'd0;
    #12;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero});
    end
    checks++;
    if (quotient !== 8'd0 || remainder !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_results: got q=%0d r=%0d expected 0 0", quotient, remainder);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL idle_flags: got %b expected 00", {busy, done});
    end
  endtask

  task automatic test_directed();
    logic [7:0] aTab [5] = '{8'd200, 8'd255, 8'd255, 8'd5, 8'd0};
    logic [7:0] bTab [5] = '{8'd7,   8'd1,   8'd255, 8'd9, 8'd3};
    int lat, busyCnt, holdErr;
    for (int i = 0; i < 5; i++) begin
      doOp(aTab[i], bTab[i], 1'b0, lat, busyCnt, holdErr);
      checks++;
      if (lat != 9 || busyCnt != 8 || holdErr != 0) begin
        errors++;
        $display("[TB] FAIL dir_timing %0d/%0d: got lat=%0d busy=%0d hold=%0d expected 9 8 0",
                 aTab[i], bTab[i], lat, busyCnt, holdErr);
      end
      checks++;
      if (quotient !== aTab[i] / bTab[i] || remainder !== aTab[i] % bTab[i] || div_by_zero !== 1'b0) begin
        errors++;
        $display("[TB] FAIL dir_result %0d/%0d: got q=%0d r=%0d z=%b expected %0d %0d 0",
                 aTab[i], bTab[i], quotient, remainder, div_by_zero,
                 aTab[i] / bTab[i], aTab[i] % bTab[i]);
      end
      expQ = aTab[i] / bTab[i];
      expR = aTab[i] % bTab[i];
      expZ = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || quotient !== expQ || remainder !== expR) begin
        errors++;
        $display("[TB] FAIL dir_pulse %0d/%0d: got done=%b q=%0d r=%0d expected 0 %0d %0d",
                 aTab[i], bTab[i], done, quotient, remainder, expQ, expR);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int lat, busyCnt, holdErr;
    doOp(8'd100, 8'd0, 1'b0, lat, busyCnt, holdErr);
    checks++;
    if (lat != 1 || busyCnt != 0 || holdErr != 0) begin
      errors++;
      $display("[TB] FAIL dbz_timing: got lat=%0d busy=%0d hold=%0d expected 1 0 0", lat, busyCnt, holdErr);
    end
    checks++;
    if (quotient !== 8'hFF || remainder !== 8'd100 || div_by_zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dbz_result: got q=%0d r=%0d z=%b expected 255 100 1", quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || div_by_zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dbz_hold: got done=%b z=%b expected 0 1", done, div_by_zero);
    end
    expQ = 8'hFF;
    expR = 8'd100;
    doOp(8'd9, 8'd3, 1'b0, lat, busyCnt, holdErr);
    checks++;
    if (lat != 9 || holdErr != 0 || quotient !== 8'd3 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dbz_clear: got lat=%0d hold=%0d q=%0d r=%0d z=%b expected 9 0 3 0 0",
               lat, holdErr, quotient, remainder, div_by_zero);
    end
    expQ = 8'd3;
    expR = 8'd0;
  endtask

  task automatic test_ignore_start();
    int lat = 0;
    int extraDone = 0;
    @(negedge clk);
    dividend = 8'd200;
    divisor = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (n == 3) begin
        start = 1'b1;
        dividend = 8'd50;
        divisor = 8'd5;
      end else begin
        start = 1'b0;
        dividend = 8'($urandom);
        divisor = 8'($urandom_range(1, 255));
      end
    end
    start = 1'b0;
    checks++;
    if (lat != 9 || quotient !== 8'd28 || remainder !== 8'd4) begin
      errors++;
      $display("[TB] FAIL ignore_start: got lat=%0d q=%0d r=%0d expected 9 28 4", lat, quotient, remainder);
    end
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) extraDone++;
    end
    checks++;
    if (extraDone != 0) begin
      errors++;
      $display("[TB] FAIL no_extra_done: got %0d extra pulses expected 0", extraDone);
    end
    expQ = 8'd28;
    expR = 8'd4;
  endtask

  task automatic test_reset_mid();
    int lat, busyCnt, holdErr;
    int doneSeen = 0;
    @(negedge clk);
    dividend = 8'd200;
    divisor = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 8'd0 || remainder !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got busy=%b done=%b z=%b q=%0d r=%0d expected all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done || busy) doneSeen++;
    end
    checks++;
    if (doneSeen != 0) begin
      errors++;
      $display("[TB] FAIL reset_quiet: got %0d active cycles expected 0", doneSeen);
    end
    expQ = 8'd0;
    expR = 8'd0;
    expZ = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    doOp(8'd17, 8'd4, 1'b1, lat, busyCnt, holdErr);
    checks++;
    if (lat != 9 || holdErr != 0 || quotient !== 8'd4 || remainder !== 8'd1) begin
      errors++;
      $display("[TB] FAIL reset_restart: got lat=%0d hold=%0d q=%0d r=%0d expected 9 0 4 1",
               lat, holdErr, quotient, remainder);
    end
    expQ = 8'd4;
    expR = 8'd1;
  endtask

  task automatic test_back_to_back();
    int lat, busyCnt, holdErr;
    doOp(8'd200, 8'd7, 1'b0, lat, busyCnt, holdErr);
    checks++;
    if (lat != 9 || quotient !== 8'd28 || remainder !== 8'd4) begin
      errors++;
      $display("[TB] FAIL b2b_first: got lat=%0d q=%0d r=%0d expected 9 28 4", lat, quotient, remainder);
    end
    expQ = 8'd28;
    expR = 8'd4;
    doOp(8'd17, 8'd4, 1'b1, lat, busyCnt, holdErr);
    checks++;
    if (lat != 9 || busyCnt != 8 || holdErr != 0 || quotient !== 8'd4 || remainder !== 8'd1) begin
      errors++;
      $display("[TB] FAIL b2b_second: got lat=%0d busy=%0d hold=%0d q=%0d r=%0d expected 9 8 0 4 1",
               lat, busyCnt, holdErr, quotient, remainder);
    end
    expQ = 8'd4;
    expR = 8'd1;
  endtask

  task automatic test_random();
    int lat, busyCnt, holdErr;
    logic [7:0] a, b, wantQ, wantR;
    for (int i = 0; i < 400; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      wantQ = (b == 0) ? 8'hFF : a / b;
      wantR = (b == 0) ? a : a % b;
      doOp(a, b, bit'($urandom_range(0, 1)), lat, busyCnt, holdErr);
      checks++;
      if (lat != ((b == 0) ? 1 : 9) || busyCnt != ((b == 0) ? 0 : 8) || holdErr != 0) begin
        errors++;
        $display("[TB] FAIL rand_timing %0d/%0d: got lat=%0d busy=%0d hold=%0d", a, b, lat, busyCnt, holdErr);
      end
      checks++;
      if (quotient !== wantQ || remainder !== wantR || div_by_zero !== (b == 0)) begin
        errors++;
        $display("[TB] FAIL rand_result %0d/%0d: got q=%0d r=%0d z=%b expected %0d %0d %b",
                 a, b, quotient, remainder, div_by_zero, wantQ, wantR, (b == 0));
      end
      expQ = wantQ;
      expR = wantR;
      expZ = (b == 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
